// File: rtl/calc_seq_ctrl.sv
// calc_seq_ctrl: turns keypad presses into operand/operator entry, launches the BCD ALU on "=",
// and holds the displayed value. Define CALC_CHAIN_EN to let an operator continue from a shown result.
module calc_seq_ctrl #(
    parameter int NDIG        = 4,
    parameter int ALU_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                btn_press,
    input  logic                is_number,
    input  logic                is_op,
    input  logic                is_eq,
    input  logic [3:0]          num_val,
    input  logic [1:0]          op_val,
    output logic [4*NDIG-1:0]   alu_a,
    output logic [4*NDIG-1:0]   alu_b,
    output logic [1:0]          alu_op,
    output logic                alu_start,
    input  logic                alu_done,
    input  logic [4*NDIG-1:0]   alu_result,
    input  logic                alu_neg,
    input  logic                alu_ovf,
    output logic [4*NDIG-1:0]   disp_bcd,
    output logic                disp_neg,
    output logic                disp_err,
    output logic [2:0]          state_dbg
);
    localparam int W  = 4*NDIG;
    localparam int CW = $clog2(NDIG+1);
    localparam int TW = $clog2(ALU_TIMEOUT+1);

    typedef enum logic [2:0] {
        ENTER_A  = 3'd0,
        ENTER_B  = 3'd1,
        WAIT_ALU = 3'd2,
        SHOW_RES = 3'd3
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, res_q, res_d;
    logic [1:0]      op_q, op_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic            press_q, start_q, start_d, neg_q, neg_d, err_q, err_d;
    logic            key_ev, dig_ev, op_ev, eq_ev, room;

    assign key_ev = btn_press & ~press_q;
    assign dig_ev = key_ev & is_number;
    assign op_ev  = key_ev & is_op & (op_val != 2'd0) & ~is_number;
    assign eq_ev  = key_ev & is_eq & ~is_number & ~is_op;
    assign room   = cnt_q != CW'(NDIG);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        tmr_d   = tmr_q;
        neg_d   = neg_q;
        err_d   = err_q;
        start_d = 1'b0;
        case (state_q)
            ENTER_A: begin
                if (dig_ev && room) begin
                    a_d   = {a_q[W-5:0], num_val};
                    cnt_d = cnt_q + CW'(1);
                end else if (op_ev) begin
                    op_d    = op_val;
                    b_d     = '0;
                    cnt_d   = '0;
                    state_d = ENTER_B;
                end
            end
            ENTER_B: begin
                if (dig_ev && room) begin
                    b_d   = {b_q[W-5:0], num_val};
                    cnt_d = cnt_q + CW'(1);
                end else if (op_ev && cnt_q == '0) begin
                    op_d = op_val;
                end else if (eq_ev && cnt_q != '0) begin
                    start_d = 1'b1;
                    tmr_d   = TW'(ALU_TIMEOUT);
                    state_d = WAIT_ALU;
                end
            end
            WAIT_ALU: begin
                // done is checked first so a completion in the expiry cycle still wins
                if (alu_done) begin
                    res_d   = alu_result;
                    neg_d   = alu_neg;
                    err_d   = alu_ovf;
                    state_d = SHOW_RES;
                end else if (tmr_q == TW'(1)) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = SHOW_RES;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            SHOW_RES: begin
                if (dig_ev) begin
                    a_d     = {{(W-4){1'b0}}, num_val};
                    b_d     = '0;
                    neg_d   = 1'b0;
                    err_d   = 1'b0;
                    cnt_d   = CW'(1);
                    state_d = ENTER_A;
                end
`ifdef CALC_CHAIN_EN
                else if (op_ev && !err_q && !neg_q) begin
                    a_d     = res_q;
                    op_d    = op_val;
                    b_d     = '0;
                    cnt_d   = '0;
                    state_d = ENTER_B;
                end
`endif
            end
            default: state_d = ENTER_A;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ENTER_A;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            tmr_q   <= '0;
            press_q <= 1'b0;
            start_q <= 1'b0;
            neg_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
            press_q <= btn_press;
            start_q <= start_d;
            neg_q   <= neg_d;
            err_q   <= err_d;
        end
    end

    // WAIT_ALU keeps showing the last entered operand until a result arrives
    assign disp_bcd  = (state_q == ENTER_A) ? a_q : (state_q == SHOW_RES) ? res_q : b_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_op    = op_q;
    assign alu_start = start_q;
    assign disp_neg  = neg_q;
    assign disp_err  = err_q;
    assign state_dbg = state_q;
endmodule

// File: doc/calc_seq_ctrl.md
Name: calc_seq_ctrl

Overview:
- Sequencing controller between the 4x4 keypad interface and the BCD arithmetic unit.
- Turns each key press into exactly one event. Accumulates operand A, the operator and operand B as packed BCD.
- Launches the ALU on "=", waits for completion with a timeout, and holds the value shown on the display.

Parameters:
NDIG, 4, BCD digits per operand; operand/result width is 4*NDIG bits.
ALU_TIMEOUT, 16, cycles to wait for alu_done after alu_start before flagging an error; minimum 2.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
btn_press  in  1  key-active flag from keypad interface, high for several cycles per press
is_number  in  1  key class: digit
is_op  in  1  key class: operator
is_eq  in  1  key class: equals
num_val  in  4  digit value 0-9
op_val  in  2  operator code: 1=add, 2=sub, 0=none
alu_a  out  4*NDIG  operand A to ALU, BCD
alu_b  out  4*NDIG  operand B to ALU, BCD
alu_op  out  2  latched operator
alu_start  out  1  one-cycle launch pulse
alu_done  in  1  one-cycle completion pulse from ALU
alu_result  in  4*NDIG  BCD magnitude of the result
alu_neg  in  1  result sign, valid with alu_done
alu_ovf  in  1  result overflow, valid with alu_done
disp_bcd  out  4*NDIG  value to display
disp_neg  out  1  display minus sign
disp_err  out  1  error indicator
state_dbg  out  3  current FSM state encoding

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - all outputs 0, state ENTER_A;
  - operands, digit counter, timeout counter and press_q all cleared.
- Reset mid-operation aborts any ALU wait immediately. A late alu_done after release is ignored because the FSM is in ENTER_A.
- Key event:
  - key_ev = btn_press & ~press_q, where press_q is btn_press registered. One event per press, however long btn_press stays high.
  - The class and value inputs are sampled in the key_ev cycle.
  - A key_ev with none of is_number/is_op/is_eq set is ignored.
  - is_op with op_val=0 is ignored.
- Digit entry, in ENTER_A and ENTER_B:
  - operand <= {operand[4*NDIG-5:0], num_val}; digit count increments.
  - Once the count reaches NDIG, further digits are ignored and the operand is unchanged.
- disp_bcd follows the operand currently being entered: A in ENTER_A, B in ENTER_B. The update appears the cycle after key_ev.
- FSM states:
  - ENTER_A (0):
    - digit -> shift into A;
    - op -> latch alu_op, clear B and digit count, go to ENTER_B;
    - eq -> ignored.
  - ENTER_B (1):
    - digit -> shift into B;
    - op -> replace alu_op only while B is empty (count 0), otherwise ignored;
    - eq with count 0 -> ignored;
    - eq with count>0 -> alu_start=1 for exactly one cycle, load timeout counter, go to WAIT_ALU.
  - WAIT_ALU (2):
    - all key events are ignored; alu_a and alu_b are held stable;
    - on alu_done: latch disp_bcd=alu_result, disp_neg=alu_neg, disp_err=alu_ovf, then go to SHOW_RES;
    - if the counter expires before done: disp_err=1, disp_bcd=0, go to SHOW_RES;
    - if alu_done arrives in the expiry cycle, done wins.
  - SHOW_RES (3):
    - digit -> clear A, B, disp_neg and disp_err; A=num_val; count=1; go to ENTER_A;
    - eq -> ignored;
    - op -> see Optional Feature.
- alu_start is never asserted outside the ENTER_B->WAIT_ALU transition.

Optional Feature:
- Macro: CALC_CHAIN_EN.
- Defined:
  - op in SHOW_RES with disp_err=0 and disp_neg=0 -> A <= displayed result, latch alu_op, clear B, go to ENTER_B;
  - op in SHOW_RES with disp_err=1 or disp_neg=1 -> ignored.
- Undefined: op in SHOW_RES is ignored. The only way out of SHOW_RES is a digit.

Test Plan:
- Keys 1,2,+,3,4,= (NDIG=4) -> alu_a=0x0012, alu_b=0x0034, alu_op=1, a single alu_start pulse. ALU returns done with 0x0046 -> disp_bcd=0x0046, state_dbg=3.
- btn_press held 10 cycles on digit 7 -> A=0x0007 (one event only). Then keys 1,2,3,4 -> A=0x7123 and the 5th digit is dropped.
- Key "=" in ENTER_A, then "=" in ENTER_B with B empty -> no alu_start, state unchanged. Key "-" then "+" with B empty -> alu_op=1.
- No alu_done for ALU_TIMEOUT cycles -> disp_err=1, disp_bcd=0, state SHOW_RES. Next digit 5 -> disp_err=0, A=0x0005.
- With CALC_CHAIN_EN: 9,+,1,= giving result 0x0010, then +,5,= -> alu_a=0x0010, alu_b=0x0005. Without the macro, that "+" leaves state at 3.
- reset pulled low during WAIT_ALU -> all outputs 0 immediately. A subsequent alu_done is ignored and state stays ENTER_A.
